// File: rtl/cache_refill_ctrl.sv
// Refill / write-back controller between the 2-way data cache and word-wide memory.
// Fetches a missing line beat by beat and drains a one-entry dirty-line buffer first.
module cache_refill_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             miss,
    input  logic [31:0]                      miss_addr,
    input  logic                             wb_valid,
    input  logic [31:0]                      wb_addr,
    input  logic [DATA_WIDTH*BLOCK_SIZE-1:0] wb_data,
    output logic [DATA_WIDTH*BLOCK_SIZE-1:0] fetch_data,
    output logic                             fetch_enable,
    output logic                             stall,
    output logic                             wb_overflow,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [31:0]                      mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic                             mem_ready,
    input  logic                             mem_rvalid,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
);

    localparam int ADDR_W = 32;
    localparam int LINE_W = DATA_WIDTH * BLOCK_SIZE;
    localparam int BEAT_W = $clog2(BLOCK_SIZE);
    localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
    localparam int OFF_W  = $clog2(BLOCK_SIZE * DATA_WIDTH / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        REFILL,
        WB_REQ
    } state_e;

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   line_base_q, line_base_d;
    logic [LINE_W-1:0]   fetch_data_q, fetch_data_d;
    logic                buf_full_q, buf_full_d;
    logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
    logic [LINE_W-1:0]   buf_data_q, buf_data_d;
    logic                wb_overflow_q, wb_overflow_d;

    logic [ADDR_W-1:0]   beat_off;
    logic                unused_bits;

    assign beat_off    = ADDR_W'(beat_q) << BYTE_W;
    assign unused_bits = ^{miss_addr[OFF_W-1:0], wb_addr[OFF_W-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            line_base_q   <= '0;
            fetch_data_q  <= '0;
            buf_full_q    <= 1'b0;
            buf_addr_q    <= '0;
            buf_data_q    <= '0;
            wb_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            line_base_q   <= line_base_d;
            fetch_data_q  <= fetch_data_d;
            buf_full_q    <= buf_full_d;
            buf_addr_q    <= buf_addr_d;
            buf_data_q    <= buf_data_d;
            wb_overflow_q <= wb_overflow_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        line_base_d   = line_base_q;
        fetch_data_d  = fetch_data_q;
        buf_full_d    = buf_full_q;
        buf_addr_d    = buf_addr_q;
        buf_data_d    = buf_data_q;
        wb_overflow_d = wb_overflow_q;

        unique case (state_q)
            IDLE: begin
                // A pending write-back always drains before the next fetch.
                if (buf_full_q) begin
                    state_d = WB_REQ;
                    beat_d  = '0;
                end else if (miss) begin
                    line_base_d = {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    state_d     = FETCH_REQ;
                    beat_d      = '0;
                end
            end
            FETCH_REQ: begin
                if (mem_ready) begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (mem_rvalid) begin
                    fetch_data_d[beat_q*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
                    if (beat_q == LAST_BEAT) begin
                        state_d = REFILL;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = FETCH_REQ;
                    end
                end
            end
            REFILL: begin
                state_d = IDLE;
            end
            WB_REQ: begin
                if (mem_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        buf_full_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A second eviction while full is dropped and flagged.
        if (wb_valid) begin
            if (buf_full_q) begin
                wb_overflow_d = 1'b1;
            end else begin
                buf_full_d = 1'b1;
                buf_addr_d = {wb_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                buf_data_d = wb_data;
            end
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        fetch_enable = 1'b0;

        unique case (state_q)
            FETCH_REQ: begin
                mem_req  = 1'b1;
                mem_addr = line_base_q + beat_off;
            end
            WB_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = buf_addr_q + beat_off;
                mem_wdata = buf_data_q[beat_q*DATA_WIDTH +: DATA_WIDTH];
            end
            REFILL: begin
                fetch_enable = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign stall       = miss & ~fetch_enable;
    assign fetch_data  = fetch_data_q;
    assign wb_overflow = wb_overflow_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a small word memory that
// answers reads one cycle after accept and records every transaction.
module tb_cache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         miss;
    logic [31:0]  miss_addr;
    logic         wb_valid;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;
    logic [127:0] fetch_data;
    logic         fetch_enable;
    logic         stall;
    logic         wb_overflow;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ready;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;

    cache_refill_ctrl #(.DATA_WIDTH(32), .BLOCK_SIZE(4)) dut (
        .clk(clk), .rst_n(rst_n), .miss(miss), .miss_addr(miss_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .fetch_data(fetch_data), .fetch_enable(fetch_enable), .stall(stall),
        .wb_overflow(wb_overflow), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n0 = 0;
    logic auto_mem;

    logic [31:0] mem_m [logic [31:0]];
    logic [31:0] rdat_q[$];
    logic [31:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // memory model: accept sampled mid-cycle, read data one cycle later
    always begin
        logic        acc_rd;
        logic [31:0] nxt;
        @(negedge clk);
        acc_rd = 1'b0;
        nxt    = '0;
        if (mem_req && mem_ready && mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_cyc_q.push_back(cyc);
            mem_m[mem_addr] = mem_wdata;
        end
        if (mem_req && mem_ready && !mem_we) begin
            rd_addr_q.push_back(mem_addr);
            rd_cyc_q.push_back(cyc);
            acc_rd = auto_mem;
            if (mem_m.exists(mem_addr)) nxt = mem_m[mem_addr];
            else if (rdat_q.size() > 0) nxt = rdat_q.pop_front();
        end
        @(posedge clk);
        #1;
        mem_rvalid = acc_rd;
        mem_rdata  = acc_rd ? nxt : 32'h0;
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        rdat_q.delete();
    endtask

    // Raise miss, run until fetch_enable, check stall every cycle and
    // optionally hold mem_ready low for bp_len cycles from cycle bp_at.
    task automatic run_miss(input logic [31:0] a, input int bp_at,
                            input int bp_len, input logic [31:0] hold_addr,
                            output int fe_k, output int fe_abs);
        int bad_stall;
        int bad_hold;
        bad_stall = 0;
        bad_hold  = 0;
        fe_k      = -1;
        fe_abs    = -1;
        miss      = 1'b1;
        miss_addr = a;
        n0        = cyc;
        for (int k = 0; k < 80; k++) begin
            mem_ready = !(k >= bp_at && k < bp_at + bp_len);
            #1;
            if (stall !== !fetch_enable) bad_stall++;
            if (k >= bp_at && k < bp_at + bp_len)
                if (!(mem_req === 1'b1 && mem_addr === hold_addr)) bad_hold++;
            if (fetch_enable === 1'b1) begin
                fe_k   = k;
                fe_abs = cyc;
                break;
            end
            @(posedge clk);
            #2;
        end
        if (fe_k < 0) check("fe_timeout", 0, 1);
        check("stall", bad_stall, 0);
        if (bp_len > 0) check("bp_hold", bad_hold, 0);
        tick();
        miss      = 1'b0;
        mem_ready = 1'b1;
    endtask

    initial begin
        int fk;
        int fa;
        int fk1;
        int fa1;
        int bad;
        rst_n      = 1'b0;
        miss       = 1'b0;
        miss_addr  = '0;
        wb_valid   = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        auto_mem   = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_fetch_en", fetch_enable, 0);
        check("rst_ovf", wb_overflow, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_fetch_data", fetch_data, 0);
        check("rst_stall", stall, 0);
        #1;
        rst_n = 1'b1;
        tick();
        tick();

        // clean read miss
        clear_logs();
        rdat_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_miss(32'h0000_1234, 0, 0, 32'h0, fk, fa);
        check("t1_fe_cyc", fk, 9);
        check("t1_nrd", rd_addr_q.size(), 4);
        for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) begin
            check($sformatf("t1_addr%0d", i), rd_addr_q[i], 32'h1230 + 4 * i);
            check($sformatf("t1_cyc%0d", i), rd_cyc_q[i] - n0, 1 + 2 * i);
        end
        check("t1_data", fetch_data, 128'h00000044_00000033_00000022_00000011);

        // eviction followed by a miss on the evicted line
        clear_logs();
        wb_valid = 1'b1;
        wb_addr  = 32'h0000_8010;
        wb_data  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        tick();
        wb_valid = 1'b0;
        run_miss(32'h0000_8010, 0, 0, 32'h0, fk, fa);
        check("t2_fe_cyc", fk, 14);
        check("t2_nwr", wr_addr_q.size(), 4);
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            check($sformatf("t2_waddr%0d", i), wr_addr_q[i], 32'h8010 + 4 * i);
            check($sformatf("t2_wdata%0d", i), wr_data_q[i], 32'hA0 + i);
            check($sformatf("t2_wcyc%0d", i), wr_cyc_q[i] - n0, 1 + i);
        end
        check("t2_nrd", rd_addr_q.size(), 4);
        if (rd_cyc_q.size() > 0) check("t2_rd_first", rd_cyc_q[0] - n0, 6);
        check("t2_data", fetch_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // backpressure on beat 2
        clear_logs();
        rdat_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_miss(32'h0000_1234, 5, 3, 32'h0000_1238, fk, fa);
        check("t3_fe_cyc", fk, 12);
        check("t3_nrd", rd_addr_q.size(), 4);
        if (rd_cyc_q.size() == 4) begin
            check("t3_cyc2", rd_cyc_q[2] - n0, 8);
            check("t3_cyc3", rd_cyc_q[3] - n0, 10);
            check("t3_addr2", rd_addr_q[2], 32'h1238);
        end
        check("t3_data", fetch_data, 128'h00000044_00000033_00000022_00000011);

        // second eviction while the buffer is full
        clear_logs();
        wb_valid = 1'b1;
        wb_addr  = 32'h0000_4000;
        wb_data  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        tick();
        wb_addr  = 32'h0000_5000;
        wb_data  = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
        tick();
        wb_valid = 1'b0;
        repeat (10) tick();
        check("t4_nwr", wr_addr_q.size(), 4);
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            check($sformatf("t4_waddr%0d", i), wr_addr_q[i], 32'h4000 + 4 * i);
            check($sformatf("t4_wdata%0d", i), wr_data_q[i], 32'hD0 + i);
        end
        check("t4_ovf", wb_overflow, 1);

        // back-to-back misses
        clear_logs();
        rdat_q = '{32'h61, 32'h62, 32'h63, 32'h64,
                   32'h65, 32'h66, 32'h67, 32'h68};
        run_miss(32'h0000_0100, 0, 0, 32'h0, fk1, fa1);
        check("t6_fe1", fk1, 9);
        check("t6_data1", fetch_data, {32'h64, 32'h63, 32'h62, 32'h61});
        run_miss(32'h0000_0200, 0, 0, 32'h0, fk, fa);
        check("t6_fe2", fk, 9);
        check("t6_nrd", rd_addr_q.size(), 8);
        bad = 0;
        for (int i = 0; i < 8 && i < rd_addr_q.size(); i++)
            if (rd_addr_q[i] !== ((i < 4) ? 32'h100 + 4 * i : 32'h200 + 4 * (i - 4)))
                bad++;
        check("t6_addrs", bad, 0);
        if (rd_cyc_q.size() > 4) check("t6_gap", rd_cyc_q[4] - fa1, 2);
        check("t6_data2", fetch_data, {32'h68, 32'h67, 32'h66, 32'h65});
        check("ovf_sticky", wb_overflow, 1);

        // reset during FETCH_WAIT of beat 1
        clear_logs();
        auto_mem  = 1'b0;
        mem_ready = 1'b1;
        miss      = 1'b1;
        miss_addr = 32'h0000_2000;
        tick();
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55;
        tick();
        #1;
        check("t5_beat1_addr", mem_addr, 32'h2004);
        tick();
        rst_n = 1'b0;
        miss  = 1'b0;
        #1;
        check("t5_req_rst", mem_req, 0);
        check("t5_fe_rst", fetch_enable, 0);
        check("t5_data_rst", fetch_data, 0);
        check("t5_ovf_rst", wb_overflow, 0);
        tick();
        tick();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (fetch_enable !== 1'b0 || mem_req !== 1'b0) bad++;
            tick();
        end
        check("t5_quiet", bad, 0);
        check("t5_data_kept", fetch_data, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Refill and write-back controller between the 2-way data cache and word-wide main memory. On a cache miss it fetches the 4-word line from memory and returns it to the cache as one 128-bit refill beat. It captures the dirty line the cache evicts into a one-entry write-back buffer and drains it to memory before serving the next miss. It also generates the pipeline stall for the duration of each miss.

## Interface
- DATA_WIDTH, 32, word width
- BLOCK_SIZE, 4, words per line; line size 16 bytes; beat counter is 2 bits
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- miss  in  1  cache access missed: (rd_en | wr_en) & !hit
- miss_addr  in  32  byte address of missing access
- wb_valid  in  1  one-cycle pulse: evicted dirty line present
- wb_addr  in  32  evicted line base address (bits [3:0] = 0)
- wb_data  in  128  evicted line; word i at [i*32 +: 32]
- fetch_data  out  128  refilled line; word i at [i*32 +: 32]
- fetch_enable  out  1  one-cycle refill pulse to cache
- stall  out  1  freeze pipeline
- wb_overflow  out  1  sticky error flag
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word-aligned byte address
- mem_wdata  out  32  write data
- mem_ready  in  1  request accepted this cycle (mem_req & mem_ready)
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data

## Operation
- FSM states: IDLE, FETCH_REQ, FETCH_WAIT, REFILL, WB_REQ.
- IDLE transitions, checked in priority order:
  - If the write-back buffer is full, go to WB_REQ, beat = 0.
  - Else if miss, latch line_base = {miss_addr[31:4], 4'b0}, go to FETCH_REQ, beat = 0.
- FETCH_REQ:
  - Drive mem_req = 1, mem_we = 0, mem_addr = line_base + 4*beat.
  - On accept, go to FETCH_WAIT.
- FETCH_WAIT:
  - On mem_rvalid, store mem_rdata into fetch_data word[beat].
  - If beat == 3, go to REFILL. Otherwise beat++ and go to FETCH_REQ.
- REFILL:
  - fetch_enable = 1 for exactly one cycle, then IDLE.
  - The cache writes the line on this edge, so miss is low on the next cycle.
- Write-back buffer (one entry: addr + 128-bit data + full flag):
  - A wb_valid pulse loads the buffer and sets full, in any state.
  - If wb_valid arrives while the buffer is already full, the pulse is dropped, the buffer keeps its old contents, and wb_overflow is set until reset.
- WB_REQ:
  - Drive mem_req = 1, mem_we = 1, mem_addr = buf_addr + 4*beat, mem_wdata = buf word[beat].
  - On accept: if beat == 3, clear full and go to IDLE; otherwise beat++.
- Ordering: a pending write-back always drains before the next fetch. A fetch of the just-evicted line therefore reads the updated data.
- mem_addr, mem_we and mem_wdata hold stable while mem_req is high and not yet accepted. mem_req deasserts in every state other than FETCH_REQ and WB_REQ.
- mem_rvalid outside FETCH_WAIT is ignored.
- stall = miss & !fetch_enable. It is combinational and stays high through any write-back drain that precedes the fetch.
- fetch_data holds its last value until the next fetch overwrites it word by word.

## Timing
- Reset (async assert, sync release):
  - Outputs: mem_req, mem_we, fetch_enable, wb_overflow all 0; mem_addr, mem_wdata, fetch_data all 0.
  - State: IDLE, buffer empty, beat 0.
- Reset mid-transaction aborts the transaction: mem_req falls immediately and a later mem_rvalid is discarded.
- Miss latency with a zero-wait memory (mem_ready = 1, mem_rvalid the cycle after accept):
  - miss seen at cycle 0.
  - Beats issue at cycles 1, 3, 5, 7.
  - fetch_enable high at cycle 9; stall high cycles 0–8.
- Each extra memory wait cycle on mem_ready or mem_rvalid adds one cycle per beat.
- Write-back drain with zero-wait memory: 4 cycles plus 1 entry cycle from IDLE.
- wb_valid arriving in the cycle after REFILL is captured and drains before any subsequent miss.

## Test plan
- Clean read miss, miss_addr 0x0000_1234, memory returns 0x11,0x22,0x33,0x44 -> reads issued at 0x1230, 0x1234, 0x1238, 0x123C; fetch_data = {0x44,0x33,0x22,0x11}; fetch_enable pulses at cycle 9.
- Eviction, wb_valid with addr 0x0000_8010 and data words A0..A3, then a miss on 0x0000_8010 -> writes of A0..A3 to 0x8010..0x801C complete before the first read; stall stays high throughout.
- Backpressure, mem_ready low for 3 cycles on beat 2 -> mem_addr 0x1238 and mem_req held stable; refill arrives 3 cycles later; data unchanged.
- Double wb_valid with the buffer full -> first entry drained intact; wb_overflow = 1 and stays 1.
- rst_n low during FETCH_WAIT at beat 1 -> mem_req 0 immediately; a subsequent mem_rvalid is ignored; state IDLE; no fetch_enable pulse.
- Back-to-back misses to 0x100 and 0x200 -> two separate 4-beat sequences, one fetch_enable pulse each, with at least one IDLE cycle between them.
